pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed EXE/MEM pipeline register. It carries a generic control+payload bundle between two pipeline stages, using valid/ready handshakes and a 2-entry skid buffer, so upstream can keep running for one cycle of downstream backpressure. It keeps the global freeze (cache-miss stall) and adds a flush for branch squash. A saturating backpressure counter feeds performance monitoring. It is instantiated at EXE->MEM and MEM->WB.

Parameters:
DATA_W, 68, payload width (ALU result 32 + Rm value 32 + dest 4)
CTRL_W, 3, control-bit width (WB_EN, MEM_R_EN, MEM_W_EN); forced to 0 on bubbles
CNT_W, 16, width of the backpressure stall counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
freeze  in  1  global stall; no transfer on either side while high
flush  in  1  squash all held entries
in_valid  in  1  upstream has a bundle
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  upstream control bits
in_data  in  DATA_W  upstream payload
out_valid  out  1  bundle presented downstream
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control bits, zero when out_valid=0
out_data  out  DATA_W  payload, undefined-but-stable when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  saturating count of backpressure cycles

Behaviour:
- Reset (rst_n=0, async): state EMPTY; main/skid valid=0; ctrl and data regs=0; stall_cnt=0. Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0 while rst_n low.
- Storage: main entry (drives outputs) and skid entry. States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
- in_ready = (state!=FULL) & ~freeze & ~flush & rst_n; combinational from state, freeze and flush only. It never depends on in_valid or out_ready.
- out_valid = main_valid & ~freeze. out_ctrl = main_ctrl masked by out_valid.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Transitions, evaluated when flush=0 and freeze=0:
  EMPTY: in_fire -> ONE, main<=in.
  ONE: in_fire & out_fire -> ONE, main<=in. in_fire & ~out_fire -> FULL, skid<=in. out_fire & ~in_fire -> EMPTY. Neither -> hold.
  FULL: out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire into EMPTY to out_valid. Order is strictly FIFO; no bundle is dropped or duplicated.
- freeze=1 (flush=0): all registers hold, including stall_cnt. No in_fire and no out_fire.
- flush=1: overrides freeze and both handshakes. Next state is EMPTY, both valids=0 and main_ctrl=0. Data regs may hold. The in_valid bundle in the flush cycle is discarded.
- stall_cnt: increments by 1 on each cycle with out_valid & ~out_ready & ~flush. Saturates at 2^CNT_W-1 with no wrap. Cleared only by reset.
- Reset asserted mid-transfer: immediate return to reset values; in-flight bundles are lost by design.

Decomposition:
- Package pipe_pkg: enum stage_state_e {ST_EMPTY, ST_ONE, ST_FULL} and occupancy constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2.
- Sub-module sat_counter (params W; ports clk, rst_n, inc, count) for stall_cnt.
- Handshake FSM and entry registers stay in pipe_stage_skid.

Test Plan:
- Reset then single bundle: ctrl=3'b101, data=0xA5, out_ready=1 -> out_valid=1 one cycle after in_fire with same values; occupancy 0->1->0.
- Backpressure: out_ready=0, send B0,B1 -> occupancy=2, in_ready=0, stall_cnt increments each cycle. Raise out_ready -> B0 then B1 in order, in_ready returns 1 after the first out_fire.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles, data 1..10 -> out_data 1..10 on consecutive cycles, occupancy stays 1, no bubbles.
- Freeze with occupancy=2: freeze for 5 cycles -> out_valid=0, in_ready=0, registers and stall_cnt unchanged. Release -> B0 presented again.
- Flush with occupancy=2 while in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, incoming bundle absent. Flush+freeze together -> flush wins.
- Saturation (CNT_W=4): 20 backpressure cycles -> stall_cnt=15 and holds. rst_n low mid-run -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage: handshake FSM states
// and the occupancy encoding reported to performance monitoring.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_of(stage_state_e s);
        case (s)
            ST_ONE:  return OCC_ONE;
            ST_FULL: return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones and is cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, global freeze,
// branch-squash flush and a saturating backpressure counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 68,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic              in_fire, out_fire;
    logic              ld_main_in, ld_main_skid, ld_skid;

    // in_ready must not look at in_valid/out_ready so it can't form a comb loop
    assign in_ready  = (state_q != ST_FULL) & ~freeze & ~flush & rst_n;
    assign out_valid = (state_q != ST_EMPTY) & ~freeze;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = occ_of(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (!freeze) begin
            case (state_q)
                ST_EMPTY: if (in_fire) begin
                    state_d    = ST_ONE;
                    ld_main_in = 1'b1;
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        ld_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: if (out_fire) begin
                    state_d      = ST_ONE;
                    ld_main_skid = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            // flushed payload may linger; only the control bits must read as a bubble
            if (flush) begin
                main_ctrl_q <= '0;
            end else if (ld_main_in) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
            end
            if (ld_skid) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready & ~flush),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized scoreboard bench for pipe_stage_skid: a FIFO-of-bundles model
// predicts order, occupancy, handshakes and the saturating stall count.
module tb_pipe_stage_skid;

    localparam int DATA_W = 68;
    localparam int CTRL_W = 3;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } item_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              freeze = 1'b0, flush = 1'b0;
    logic              in_valid = 1'b0, out_ready = 1'b0;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
    logic [DATA_W-1:0] in_data = '0, out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    item_t q[$];
    int    exp_cnt = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor / scoreboard. Inputs change just after posedge, so the values
    // seen at negedge are exactly what the next posedge will act on.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (clk) #1;  // async assertion mid-cycle: look without any clock edge
            q.delete();
            exp_cnt = 0;
            checks++;
            if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 ||
                occupancy !== 2'd0 || in_ready !== 1'b0 || stall_cnt !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got v=%b c=%h d=%h occ=%0d rdy=%b cnt=%0d, want all zero",
                         out_valid, out_ctrl, out_data, occupancy, in_ready, stall_cnt);
            end
        end else begin
            automatic bit exp_valid = (q.size() > 0) && !freeze;
            automatic bit exp_ready = (q.size() < 2) && !freeze && !flush;
            checks++;
            if (occupancy !== 2'(q.size())) begin
                errors++;
                $display("FAIL occupancy: got %0d want %0d", occupancy, q.size());
            end
            checks++;
            if (out_valid !== exp_valid) begin
                errors++;
                $display("FAIL out_valid: got %b want %b", out_valid, exp_valid);
            end
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", in_ready, exp_ready);
            end
            checks++;
            if (stall_cnt !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_cnt);
            end
            checks++;
            if (exp_valid) begin
                if (out_ctrl !== q[0].c || out_data !== q[0].d) begin
                    errors++;
                    $display("FAIL out_bundle: got c=%h d=%h want c=%h d=%h",
                             out_ctrl, out_data, q[0].c, q[0].d);
                end
            end else if (out_ctrl !== '0) begin
                errors++;
                $display("FAIL bubble_ctrl: got %h want 0", out_ctrl);
            end
            // advance the model to what the coming posedge does
            if (exp_valid && !out_ready && !flush && exp_cnt < (1 << CNT_W) - 1)
                exp_cnt++;
            if (flush) begin
                q.delete();
            end else if (!freeze) begin
                if (exp_valid && out_ready) void'(q.pop_front());
                if (in_valid && exp_ready) q.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    task automatic step(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input bit rdy, input bit frz, input bit fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = rdy;
        freeze    = frz;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    task automatic rand_traffic(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 3) != 0, CTRL_W'($urandom()), rnd_data(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, '0, '0, 1, 0, 0);

        // single bundle through an empty stage
        step(1, 3'b101, 68'hA5, 1, 0, 0);
        repeat (3) step(0, '0, '0, 1, 0, 0);

        // backpressure: fill both entries, then drain in order
        step(1, 3'b001, 68'hB0, 0, 0, 0);
        step(1, 3'b010, 68'hB1, 0, 0, 0);
        repeat (4) step(0, '0, '0, 0, 0, 0);
        repeat (3) step(0, '0, '0, 1, 0, 0);

        // streaming 1..10 with no bubbles
        for (int i = 1; i <= 10; i++) step(1, 3'b100, DATA_W'(i), 1, 0, 0);
        repeat (2) step(0, '0, '0, 1, 0, 0);

        // freeze while full, then release
        step(1, 3'b011, 68'hC0, 0, 0, 0);
        step(1, 3'b110, 68'hC1, 0, 0, 0);
        repeat (5) step(1, 3'b111, 68'hDEAD, 1, 1, 0);
        repeat (3) step(0, '0, '0, 1, 0, 0);

        // flush while full with an incoming bundle; then flush+freeze
        step(1, 3'b001, 68'hD0, 0, 0, 0);
        step(1, 3'b001, 68'hD1, 0, 0, 0);
        step(1, 3'b111, 68'hEE, 1, 0, 1);
        step(0, '0, '0, 1, 0, 0);
        step(1, 3'b101, 68'hD2, 0, 0, 0);
        step(1, 3'b111, 68'hEF, 1, 1, 1);
        repeat (2) step(0, '0, '0, 1, 0, 0);

        // saturation of the 4-bit stall counter
        step(1, 3'b010, 68'h5A, 0, 0, 0);
        repeat (20) step(0, '0, '0, 0, 0, 0);
        repeat (2) step(0, '0, '0, 1, 0, 0);

        rand_traffic(400);

        // asynchronous reset in the middle of a cycle with traffic in flight
        step(1, 3'b111, 68'h77, 0, 0, 0);
        step(1, 3'b110, 68'h78, 0, 0, 0);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rand_traffic(300);
        repeat (3) step(0, '0, '0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
